// File: rtl/segment_display_decoder_pkg.sv
// Shared definitions for the multiplexed seven-segment display decoder.
//   - Segment bit positions and single-bit masks (active-high pattern view)
//   - 16-entry hex decode table, indexed by hex value
//   - FSM state enumeration
//   - single_low(): true when exactly one active-low select line is asserted
package segment_display_decoder_pkg;

    localparam int NUM_SEGMENTS = 7;
    localparam int NUM_DIGITS   = 4;

    // Segment bit positions
    localparam int SEG_TOP          = 0;
    localparam int SEG_RIGHT_TOP    = 1;
    localparam int SEG_RIGHT_BOTTOM = 2;
    localparam int SEG_BOTTOM       = 3;
    localparam int SEG_LEFT_BOTTOM  = 4;
    localparam int SEG_LEFT_TOP     = 5;
    localparam int SEG_CENTER       = 6;

    // Single-segment masks in the active-high pattern view
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_TOP          = 7'(1 << SEG_TOP);
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_RIGHT_TOP    = 7'(1 << SEG_RIGHT_TOP);
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_RIGHT_BOTTOM = 7'(1 << SEG_RIGHT_BOTTOM);
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_BOTTOM       = 7'(1 << SEG_BOTTOM);
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_LEFT_BOTTOM  = 7'(1 << SEG_LEFT_BOTTOM);
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_LEFT_TOP     = 7'(1 << SEG_LEFT_TOP);
    localparam logic [NUM_SEGMENTS-1:0] SEG_MASK_CENTER       = 7'(1 << SEG_CENTER);

    // Active-high segment pattern for each hex value 0..F
    localparam logic [NUM_SEGMENTS-1:0] DECODE_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Exactly one active-low line asserted (power-of-two test on the inverse)
    function automatic logic single_low(input logic [NUM_DIGITS-1:0] sel_n);
        logic [NUM_DIGITS-1:0] act;
        act = ~sel_n;
        return (act != '0) && ((act & (act - 4'd1)) == '0);
    endfunction

endpackage

// File: rtl/segment_display_decoder_lookup.sv
// segment_pattern_lookup: combinational reverse lookup of the hex decode table.
//   pattern : active-high 7-bit segment pattern
//   value   : hex value whose table entry matches (0 when no match)
//   hit     : high when the pattern is one of the 16 table entries
module segment_pattern_lookup
    import segment_display_decoder_pkg::*;
(
    input  logic [NUM_SEGMENTS-1:0] pattern,
    output logic [3:0]              value,
    output logic                    hit
);

    // Table entries are unique, so at most one index can match.
    always_comb begin
        value = 4'd0;
        hit   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == DECODE_TABLE[i]) begin
                value = 4'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segment_display_decoder.sv
// segment_display_decoder: snoops the pins of a multiplexed 4-digit
// seven-segment display and recovers the hex value shown on each digit.
//   clock, reset   : single clock, asynchronous active-high reset
//   segmentEnableN : active-low segment lines (bit 0 top ... bit 6 center)
//   digitEnableN   : active-low digit selects
//   digitValues    : decoded value per digit, digit i at [4i+3:4i]
//   digitValid     : digit holds a recognized, non-stale pattern
//   digitUpdate    : one-cycle pulse per captured digit
//   frameDone      : one-cycle pulse once all four digits have been captured
module segment_display_decoder
    import segment_display_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000
)
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SEGMENTS-1:0] segmentEnableN,
    input  logic [NUM_DIGITS-1:0]   digitEnableN,
    output logic [4*NUM_DIGITS-1:0] digitValues,
    output logic [NUM_DIGITS-1:0]   digitValid,
    output logic [NUM_DIGITS-1:0]   digitUpdate,
    output logic                    frameDone
);

    // The counter leaves SETTLE on the edge where it reaches STABLE_CYCLES-1.
    localparam logic [7:0]  SETTLE_LAST = 8'(STABLE_CYCLES - 2);
    localparam logic [19:0] TIMEOUT_AGE = 20'(TIMEOUT_CYCLES);

    logic [NUM_SEGMENTS-1:0] seg_sync1_q, seg_sync1_d, seg_sync2_q, seg_sync2_d;
    logic [NUM_SEGMENTS-1:0] seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0]   dig_sync1_q, dig_sync1_d, dig_sync2_q, dig_sync2_d;
    logic [NUM_DIGITS-1:0]   dig_prev_q, dig_prev_d;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   update_q, update_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_q, frame_d;

    logic                    sample_changed;
    logic                    capture_en;
    logic [NUM_DIGITS-1:0]   capture_sel;
    logic [3:0]              lookup_value;
    logic                    lookup_hit;

    // Two-flop synchronizers plus one more stage holding the previous sample
    always_comb begin
        seg_sync1_d = segmentEnableN;
        dig_sync1_d = digitEnableN;
        seg_sync2_d = seg_sync1_q;
        dig_sync2_d = dig_sync1_q;
        seg_prev_d  = seg_sync2_q;
        dig_prev_d  = dig_sync2_q;
    end

    assign sample_changed = (seg_sync2_q != seg_prev_q) || (dig_sync2_q != dig_prev_q);

    // Next-state logic: a changed sample always restarts settling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_changed) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q >= SETTLE_LAST) begin
                        state_d = single_low(dig_prev_q) ? ST_CAPTURE : ST_HOLD;
                    end
                end
                ST_CAPTURE: state_d = ST_HOLD;
                ST_HOLD:    state_d = ST_HOLD;
                default:    state_d = ST_SETTLE;
            endcase
        end
    end

    // During CAPTURE, prev still holds the sample that was stable while settling.
    assign capture_en  = (state_q == ST_CAPTURE) && single_low(dig_prev_q);
    assign capture_sel = capture_en ? ~dig_prev_q : '0;

    segment_pattern_lookup u_lookup (
        .pattern (~seg_prev_q),
        .value   (lookup_value),
        .hit     (lookup_hit)
    );

    // Update pulse and frame tracking; the seen mask self-clears on completion.
    always_comb begin
        update_d = capture_sel;
        seen_d   = seen_q | capture_sel;
        frame_d  = 1'b0;
        if (seen_d == '1) begin
            frame_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_sync1_q <= '1;
            seg_sync2_q <= '1;
            seg_prev_q  <= '1;
            dig_sync1_q <= '1;
            dig_sync2_q <= '1;
            dig_prev_q  <= '1;
            state_q     <= ST_SETTLE;
            cnt_q       <= 8'd0;
            update_q    <= '0;
            seen_q      <= '0;
            frame_q     <= 1'b0;
        end else begin
            seg_sync1_q <= seg_sync1_d;
            seg_sync2_q <= seg_sync2_d;
            seg_prev_q  <= seg_prev_d;
            dig_sync1_q <= dig_sync1_d;
            dig_sync2_q <= dig_sync2_d;
            dig_prev_q  <= dig_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            update_q    <= update_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
        end
    end

    // Per-digit value, valid flag and staleness counter
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0]  value_q, value_d;
            logic        valid_q, valid_d;
            logic [19:0] age_q, age_d;

            // Capture takes priority over a timeout landing on the same edge.
            always_comb begin
                value_d = value_q;
                valid_d = valid_q;
                age_d   = (age_q >= TIMEOUT_AGE) ? TIMEOUT_AGE : age_q + 20'd1;
                if (capture_sel[gi]) begin
                    value_d = lookup_value;
                    valid_d = lookup_hit;
                    age_d   = 20'd0;
                end else if (age_d == TIMEOUT_AGE) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    value_q <= 4'd0;
                    valid_q <= 1'b0;
                    age_q   <= 20'd0;
                end else begin
                    value_q <= value_d;
                    valid_q <= valid_d;
                    age_q   <= age_d;
                end
            end

            assign digitValues[4*gi +: 4] = value_q;
            assign digitValid[gi]         = valid_q;
        end
    endgenerate

    assign digitUpdate = update_q;
    assign frameDone   = frame_q;

endmodule

// File: tb/tb_segment_display_decoder.sv
module tb_segment_display_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] digitValues;
    logic [3:0]  digitValid;
    logic [3:0]  digitUpdate;
    logic        frameDone;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference decode table (active-high pattern per hex value)
    logic [6:0] ref_table [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int         edge_no;
        int         idx;
        logic [3:0] upd;
        logic [3:0] val;
        logic       valid;
        logic       frame;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] seen_model = 4'h0;

    segment_display_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .segmentEnableN (seg_n),
        .digitEnableN   (dig_n),
        .digitValues    (digitValues),
        .digitValid     (digitValid),
        .digitUpdate    (digitUpdate),
        .frameDone      (frameDone)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the pins (called at a negedge); when a capture is expected,
    // push the predicted result and its edge number to the scoreboard.
    task automatic apply(input logic [6:0] seg, input logic [3:0] dig,
                         input bit expect_capture, output int edge_no);
        exp_t e;
        logic [6:0] pat;
        seg_n   = seg;
        dig_n   = dig;
        edge_no = cyc + 3 + STABLE;
        if (expect_capture) begin
            pat       = ~seg;
            e.edge_no = edge_no;
            e.upd     = ~dig;
            e.idx     = 0;
            for (int i = 0; i < 4; i++) if (!dig[i]) e.idx = i;
            e.val   = 4'd0;
            e.valid = 1'b0;
            for (int v = 0; v < 16; v++) begin
                if (ref_table[v] == pat) begin
                    e.val   = 4'(v);
                    e.valid = 1'b1;
                end
            end
            seen_model = seen_model | ~dig;
            e.frame    = (seen_model == 4'hF);
            if (e.frame) seen_model = 4'h0;
            sb.push_back(e);
        end
    endtask

    // Scoreboard consumer: every update/frame pulse must match the next expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (digitUpdate != 4'h0 || frameDone)) begin
            if (sb.size() == 0) begin
                check("unexpected_update", {27'b0, frameDone, digitUpdate}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("update_edge",  cyc, e.edge_no);
                check("update_mask",  digitUpdate, e.upd);
                check("update_value", digitValues[4*e.idx +: 4], e.val);
                check("update_valid", digitValid[e.idx], e.valid);
                check("frame_done",   frameDone, e.frame);
                $display("capture digit %0d value %0h valid %0b frame %0b at edge %0d",
                         e.idx, digitValues[4*e.idx +: 4], digitValid[e.idx], frameDone, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ed;
        int          e_timeout;
        int          k;
        logic [6:0]  cur_seg;
        logic [15:0] snap_vals;
        logic [3:0]  snap_valid;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_values", digitValues, 16'h0);
        check("reset_valid",  digitValid, 4'h0);
        check("reset_update", digitUpdate, 4'h0);
        check("reset_frame",  frameDone, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single capture of '2' on digit 0
        apply(~7'h5B, 4'b1110, 1, ed);
        repeat (10) @(negedge clock);
        check("d0_value", digitValues[3:0], 4'h2);
        check("d0_valid", digitValid, 4'b0001);

        // Scan 1, A, d, F across digits 0..3
        apply(~7'h06, 4'b1110, 1, ed); repeat (8) @(negedge clock);
        apply(~7'h77, 4'b1101, 1, ed); repeat (8) @(negedge clock);
        apply(~7'h5E, 4'b1011, 1, ed); repeat (8) @(negedge clock);
        apply(~7'h71, 4'b0111, 1, ed); repeat (8) @(negedge clock);
        check("scan_values", digitValues, 16'hFDA1);
        check("scan_valid",  digitValid, 4'hF);

        // Glitching segment: never stable long enough to capture
        snap_vals  = digitValues;
        snap_valid = digitValid;
        cur_seg    = ~7'h71;
        for (int i = 0; i < 7; i++) begin
            cur_seg = cur_seg ^ 7'h01;
            apply(cur_seg, 4'b0111, 0, ed);
            repeat (3) @(negedge clock);
        end
        check("glitch_values", digitValues, snap_vals);
        check("glitch_valid",  digitValid, snap_valid);
        cur_seg = cur_seg ^ 7'h01;
        apply(cur_seg, 4'b0111, 1, ed);
        repeat (10) @(negedge clock);

        // Timeout: capture 8 on digit 2, then deselect everything
        apply(~7'h7F, 4'b1011, 1, e_timeout);
        repeat (10) @(negedge clock);
        apply(~7'h7F, 4'b1111, 0, ed);
        while (cyc < e_timeout + TIMEOUT - 1) @(negedge clock);
        check("d2_valid_before_timeout", digitValid[2], 1'b1);
        @(negedge clock);
        check("d2_valid_after_timeout", digitValid[2], 1'b0);
        check("d2_value_kept",          digitValues[11:8], 4'h8);

        // Unrecognized pattern on digit 1, then a two-digit select
        apply(~7'h01, 4'b1101, 1, ed);
        repeat (10) @(negedge clock);
        check("d1_bad_value", digitValues[7:4], 4'h0);
        check("d1_bad_valid", digitValid[1], 1'b0);
        snap_vals = digitValues;
        apply(~7'h3F, 4'b1100, 0, ed);
        repeat (12) @(negedge clock);
        check("multi_select_values", digitValues, snap_vals);

        // Reset asserted during the CAPTURE cycle
        apply(~7'h06, 4'b1110, 0, ed);
        k = cyc;
        while (cyc < k + 2 + STABLE) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_cap_values", digitValues, 16'h0);
        check("rst_cap_valid",  digitValid, 4'h0);
        check("rst_cap_update", digitUpdate, 4'h0);
        check("rst_cap_frame",  frameDone, 1'b0);
        repeat (2) @(negedge clock);
        reset      = 1'b0;
        seen_model = 4'h0;
        apply(~7'h06, 4'b1110, 1, ed);
        repeat (12) @(negedge clock);
        check("post_reset_value", digitValues[3:0], 4'h1);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
